ysq_squarer_core: RTL and testbench

Sequential shift-add squarer computing y² for an unsigned W-bit operand. It sits directly downstream of the tt_um_ysquare pin wrapper. The wrapper presents operands from its dedicated inputs through a valid/ready handshake and drives its outputs from this block's result. One operand is in flight at a time; the result is held until the consumer takes it.

---
 rtl/ysq_pkg.sv | 18 +
 rtl/ysq_squarer_core.sv | 114 +++++++++++
 tb/tb_ysq_squarer_core.sv | 236 +++++++++++++++++++++++
 3 files changed

// File: rtl/ysq_pkg.sv
// rtl/ysq_pkg.sv - shared types and constants for the shift-add squarer
package ysq_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        DONE = 2'd2
    } ysq_state_t;

    localparam int YSQ_W = 8;
    localparam int YSQ_CNT_W = $clog2(YSQ_W);

    // Eight guard bits let the running sum of squares absorb many results before wrapping.
    function automatic int acc_w(input int w);
        return 2 * w + 8;
    endfunction

endpackage

// File: rtl/ysq_squarer_core.sv
// rtl/ysq_squarer_core.sv - sequential shift-add squarer, optional YSQ_ACCUM_EN sum-of-squares accumulator
module ysq_squarer_core
    import ysq_pkg::*;
#(
    parameter int W = YSQ_W
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [W-1:0]          in_y,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [2*W-1:0]        out_sq,
    output logic                  busy,
    output logic [acc_w(W)-1:0]   out_acc
);

    localparam int AW = acc_w(W);
    localparam int CW = (W > 1) ? $clog2(W) : 1;

    ysq_state_t        state_q;
    ysq_state_t        state_d;
    logic [2*W-1:0]    mcand;
    logic [W-1:0]      mult;
    logic [2*W-1:0]    prod;
    logic [CW-1:0]     cnt;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        in_ready  = 1'b0;
        out_valid = 1'b0;
        busy      = 1'b0;
        case (state_q)
            IDLE: begin
                in_ready = 1'b1;
                if (in_valid) begin
                    state_d = CALC;
                end
            end
            CALC: begin
                busy = 1'b1;
                if (cnt == CW'(W - 1)) begin
                    state_d = DONE;
                end
            end
            DONE: begin
                busy      = 1'b1;
                out_valid = 1'b1;
                if (out_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // One multiplier bit per CALC cycle; the fixed W-cycle run keeps latency data-independent.
    always_ff @(posedge clk) begin
        if (rst) begin
            mcand <= '0;
            mult  <= '0;
            prod  <= '0;
            cnt   <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (in_valid) begin
                        mcand <= {{W{1'b0}}, in_y};
                        mult  <= in_y;
                        prod  <= '0;
                        cnt   <= '0;
                    end
                end
                CALC: begin
                    if (mult[0]) begin
                        prod <= prod + mcand;
                    end
                    mcand <= mcand << 1;
                    mult  <= mult >> 1;
                    cnt   <= cnt + 1'b1;
                end
                default: ;
            endcase
        end
    end

    assign out_sq = prod;

`ifdef YSQ_ACCUM_EN
    logic [AW-1:0] acc_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            acc_q <= '0;
        end else if (state_q == DONE && out_ready) begin
            acc_q <= acc_q + AW'(prod);
        end
    end

    assign out_acc = acc_q;
`else
    assign out_acc = '0;
`endif

endmodule

// File: tb/tb_ysq_squarer_core.sv
// tb/tb_ysq_squarer_core.sv - self-checking bench for ysq_squarer_core
module tb_ysq_squarer_core;
    import ysq_pkg::*;

    localparam int W  = YSQ_W;
    localparam int AW = acc_w(W);

    logic              clk = 1'b0;
    logic              rst;
    logic              in_valid;
    logic              in_ready;
    logic [W-1:0]      in_y;
    logic              out_valid;
    logic              out_ready;
    logic [2*W-1:0]    out_sq;
    logic              busy;
    logic [AW-1:0]     out_acc;

    ysq_squarer_core #(.W(W)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_y      (in_y),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_sq    (out_sq),
        .busy      (busy),
        .out_acc   (out_acc)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;
    int acc_cyc[$];
    int acc_val[$];
    longint res_val[$];
    logic [AW-1:0] exp_acc;

    // Handshake log: accepted operands and taken results, in edge order.
    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (!rst) begin
            if (in_valid && in_ready) begin
                acc_cyc.push_back(cyc);
                acc_val.push_back(int'(in_y));
            end
            if (out_valid && out_ready) begin
                res_val.push_back(longint'(out_sq));
            end
        end
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [AW-1:0] acc_expect();
`ifdef YSQ_ACCUM_EN
        return exp_acc;
`else
        return '0;
`endif
    endfunction

    function automatic logic [2*W-1:0] square(input int y);
        longint s;
        s = longint'(y) * longint'(y);
        return s[2*W-1:0];
    endfunction

    task automatic clear_log();
        acc_cyc.delete();
        acc_val.delete();
        res_val.delete();
    endtask

    task automatic run_op(input int y, input int hold, input string tag);
        int lat;
        logic [2*W-1:0] exp;
        exp = square(y);
        check({tag, "_ready_idle"}, 64'(in_ready), 64'd1);
        in_valid = 1'b1;
        in_y     = W'(y);
        tick();
        in_valid = 1'b0;
        in_y     = W'($urandom);
        check({tag, "_busy"}, 64'(busy), 64'd1);
        check({tag, "_ready_calc"}, 64'(in_ready), 64'd0);
        lat = 0;
        while (!out_valid && lat < 3 * W) begin
            tick();
            lat++;
        end
        check({tag, "_latency"}, 64'(lat), 64'(W));
        check({tag, "_sq"}, 64'(out_sq), 64'(exp));
        for (int i = 0; i < hold; i++) begin
            tick();
            check({tag, "_hold_sq"}, 64'(out_sq), 64'(exp));
            check({tag, "_hold_valid"}, 64'(out_valid), 64'd1);
        end
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        exp_acc = exp_acc + AW'(exp);
        check({tag, "_valid_drop"}, 64'(out_valid), 64'd0);
        check({tag, "_acc"}, 64'(out_acc), 64'(acc_expect()));
    endtask

    initial begin
        int n;
        rst       = 1'b1;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        in_y      = '0;
        exp_acc   = '0;
        repeat (2) tick();
        rst = 1'b0;
        check("rst_ready", 64'(in_ready), 64'd1);
        check("rst_valid", 64'(out_valid), 64'd0);
        check("rst_busy", 64'(busy), 64'd0);
        check("rst_sq", 64'(out_sq), 64'd0);
        check("rst_acc", 64'(out_acc), 64'd0);

        run_op(255, 0, "y255");

        // Back-to-back with in_valid held: 0 then 1.
        clear_log();
        in_valid  = 1'b1;
        in_y      = '0;
        out_ready = 1'b1;
        tick();
        in_y = W'(1);
        n = 0;
        while (acc_cyc.size() < 2 && n < 40) begin
            tick();
            n++;
        end
        in_valid = 1'b0;
        n = 0;
        while (res_val.size() < 2 && n < 40) begin
            tick();
            n++;
        end
        repeat (15) tick();
        out_ready = 1'b0;
        exp_acc = exp_acc + AW'(square(0)) + AW'(square(1));
        check("b2b_count", 64'(res_val.size()), 64'd2);
        check("b2b_res0", (res_val.size() > 0) ? 64'(res_val[0]) : 64'hFFFF, 64'(square(0)));
        check("b2b_res1", (res_val.size() > 1) ? 64'(res_val[1]) : 64'hFFFF, 64'(square(1)));
        check("b2b_spacing", (acc_cyc.size() > 1) ? 64'(acc_cyc[1] - acc_cyc[0]) : 64'd0, 64'(W + 2));
        check("b2b_acc", 64'(out_acc), 64'(acc_expect()));

        // Stalled consumer with a second operand waiting.
        clear_log();
        in_valid = 1'b1;
        in_y     = W'(13);
        tick();
        in_y = W'(99);
        n = 0;
        while (!out_valid && n < 40) begin
            tick();
            n++;
        end
        check("stall_sq", 64'(out_sq), 64'(square(13)));
        for (int i = 0; i < 5; i++) begin
            tick();
            check("stall_hold_sq", 64'(out_sq), 64'(square(13)));
            check("stall_hold_ready", 64'(in_ready), 64'd0);
        end
        check("stall_one_accept", 64'(acc_cyc.size()), 64'd1);
        out_ready = 1'b1;
        tick();
        check("stall_idle_ready", 64'(in_ready), 64'd1);
        tick();
        in_valid = 1'b0;
        n = 0;
        while (res_val.size() < 2 && n < 40) begin
            tick();
            n++;
        end
        out_ready = 1'b0;
        exp_acc = exp_acc + AW'(square(13)) + AW'(square(99));
        check("stall_res0", (res_val.size() > 0) ? 64'(res_val[0]) : 64'hFFFF, 64'(square(13)));
        check("stall_res1", (res_val.size() > 1) ? 64'(res_val[1]) : 64'hFFFF, 64'(square(99)));
        check("stall_next_val", (acc_val.size() > 1) ? 64'(acc_val[1]) : 64'hFFFF, 64'd99);
        check("stall_acc", 64'(out_acc), 64'(acc_expect()));

        // Reset at CALC cycle 4 discards the operation.
        clear_log();
        in_valid = 1'b1;
        in_y     = W'(200);
        tick();
        in_valid = 1'b0;
        repeat (4) tick();
        rst = 1'b1;
        repeat (2) tick();
        rst = 1'b0;
        exp_acc = '0;
        check("mid_rst_ready", 64'(in_ready), 64'd1);
        check("mid_rst_busy", 64'(busy), 64'd0);
        check("mid_rst_sq", 64'(out_sq), 64'd0);
        check("mid_rst_acc", 64'(out_acc), 64'd0);
        out_ready = 1'b1;
        n = 0;
        for (int i = 0; i < 3 * W; i++) begin
            tick();
            if (out_valid) n++;
        end
        out_ready = 1'b0;
        check("mid_rst_no_valid", 64'(n), 64'd0);
        check("mid_rst_no_result", 64'(res_val.size()), 64'd0);
        run_op(3, 0, "y3");
        run_op(4, 1, "y4");

        for (int k = 0; k < 20; k++) begin
            run_op(int'($urandom_range(0, (1 << W) - 1)), int'($urandom_range(0, 3)), "rand");
        end
        run_op(0, 2, "y0");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
